// File: rtl/table_stream_loader.sv
// Run-time loadable addr->data lookup table.
// Stream words fill entries 0..DEPTH-1 in order; reads are combinational.
module table_stream_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              loading,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid_bits;
    logic              xfer;
    logic              last;

    assign xfer = wr_valid && wr_ready;
    assign last = (wr_count == LAST_IDX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: any load_start (re)enters LOAD; final transfer completes
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (load_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (xfer && last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: a restart pulse blocks the transfer in its own cycle
    always_comb begin
        loading  = 1'b0;
        wr_ready = 1'b0;
        if (state == LOAD) begin
            loading  = 1'b1;
            wr_ready = !load_start;
        end
    end

    // Write counter and completion flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
            done     <= 1'b0;
        end else if (load_start) begin
            wr_count <= '0;
            done     <= 1'b0;
        end else if (xfer) begin
            wr_count <= wr_count + 1'b1;
            if (last) begin
                done <= 1'b1;
            end
        end
    end

    // Per-entry valid bits, cleared on every (re)load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_bits <= '0;
        end else if (load_start) begin
            valid_bits <= '0;
        end else if (xfer) begin
            valid_bits[wr_count[ADDR_W-1:0]] <= 1'b1;
        end
    end

    // Table storage; contents survive a restart, only reset zeroes them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (xfer) begin
            mem[wr_count[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data  = mem[rd_addr];
    assign rd_valid = valid_bits[rd_addr];

endmodule

// File: tb/tb_table_stream_loader.sv
// Directed bench for table_stream_loader.
// Each task drives one scenario and checks its own expected values.
module tb_table_stream_loader;

    logic       clk;
    logic       rst;
    logic       load_start;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       loading;
    logic       done;
    logic [4:0] wr_count;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] stream [16] = '{
        8'd0, 8'd1, 8'd6, 8'd11, 8'd20, 8'd37, 8'd70, 8'd135,
        8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15
    };

    table_stream_loader #(
        .ADDR_W(4),
        .DATA_W(8),
        .DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .loading   (loading),
        .done      (done),
        .wr_count  (wr_count),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        load_start = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = 8'h00;
        rd_addr    = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_chk++;
        if ({wr_ready, loading, done, wr_count} !== 8'h00)
            $display("FAIL reset_outputs got rdy=%b ld=%b dn=%b cnt=%0d want 0",
                     wr_ready, loading, done, wr_count);
        else n_pass++;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            n_chk++;
            if (rd_data !== 8'h00 || rd_valid !== 1'b0)
                $display("FAIL reset_read[%0d] got %0d/%b want 0/0",
                         a, rd_data, rd_valid);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n_chk++;
        if (loading !== 1'b1 || wr_count !== 5'd0 || done !== 1'b0)
            $display("FAIL b2b_enter got ld=%b cnt=%0d dn=%b want 1/0/0",
                     loading, wr_count, done);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = stream[i];
            #1;
            n_chk++;
            if (wr_ready !== 1'b1 || wr_count !== 5'(i) || done !== 1'b0)
                $display("FAIL b2b_word[%0d] got rdy=%b cnt=%0d dn=%b want 1/%0d/0",
                         i, wr_ready, wr_count, done, i);
            else n_pass++;
            tick();
        end
        wr_valid = 1'b0;
        n_chk++;
        if (done !== 1'b1 || wr_count !== 5'd16 || loading !== 1'b0)
            $display("FAIL b2b_done got dn=%b cnt=%0d ld=%b want 1/16/0",
                     done, wr_count, loading);
        else n_pass++;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            n_chk++;
            if (rd_data !== stream[a] || rd_valid !== 1'b1)
                $display("FAIL b2b_read[%0d] got %0d/%b want %0d/1",
                         a, rd_data, rd_valid, stream[a]);
            else n_pass++;
        end
    endtask

    task automatic test_gaps();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b0;
            wr_data  = 8'hXX;
            for (int g = 0; g < (i % 3) + 1; g++) begin
                tick();
                n_chk++;
                if (wr_count !== 5'(i))
                    $display("FAIL gap_count[%0d] got %0d want %0d",
                             i, wr_count, i);
                else n_pass++;
            end
            wr_valid = 1'b1;
            wr_data  = stream[i];
            tick();
        end
        wr_valid = 1'b0;
        n_chk++;
        if (done !== 1'b1 || wr_count !== 5'd16)
            $display("FAIL gap_done got dn=%b cnt=%0d want 1/16", done, wr_count);
        else n_pass++;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            n_chk++;
            if (rd_data !== stream[a] || rd_valid !== 1'b1)
                $display("FAIL gap_read[%0d] got %0d/%b want %0d/1",
                         a, rd_data, rd_valid, stream[a]);
            else n_pass++;
        end
    endtask

    task automatic test_restart();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hA0 + 8'(i);
            tick();
        end
        load_start = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = 8'hEE;
        #1;
        n_chk++;
        if (wr_ready !== 1'b0)
            $display("FAIL restart_ready got %b want 0", wr_ready);
        else n_pass++;
        tick();
        load_start = 1'b0;
        wr_valid   = 1'b0;
        n_chk++;
        if (wr_count !== 5'd0 || loading !== 1'b1)
            $display("FAIL restart_state got cnt=%0d ld=%b want 0/1",
                     wr_count, loading);
        else n_pass++;
        for (int a = 0; a < 6; a++) begin
            logic [7:0] exp_d;
            exp_d   = (a < 5) ? 8'hA0 + 8'(a) : stream[a];
            rd_addr = 4'(a);
            #1;
            n_chk++;
            if (rd_data !== exp_d || rd_valid !== 1'b0)
                $display("FAIL restart_keep[%0d] got %0h/%b want %0h/0",
                         a, rd_data, rd_valid, exp_d);
            else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h50 + 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            n_chk++;
            if (rd_data !== 8'h50 + 8'(a) || rd_valid !== 1'b1)
                $display("FAIL restart_reload[%0d] got %0h/%b want %0h/1",
                         a, rd_data, rd_valid, 8'h50 + 8'(a));
            else n_pass++;
        end
    endtask

    task automatic test_done_hold();
        for (int c = 0; c < 10; c++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hFF;
            #1;
            n_chk++;
            if (wr_ready !== 1'b0 || wr_count !== 5'd16 || done !== 1'b1)
                $display("FAIL hold_cycle[%0d] got rdy=%b cnt=%0d dn=%b want 0/16/1",
                         c, wr_ready, wr_count, done);
            else n_pass++;
            tick();
        end
        wr_valid = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            n_chk++;
            if (rd_data !== 8'h50 + 8'(a) || rd_valid !== 1'b1)
                $display("FAIL hold_read[%0d] got %0h/%b want %0h/1",
                         a, rd_data, rd_valid, 8'h50 + 8'(a));
            else n_pass++;
        end
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n_chk++;
        if (loading !== 1'b1 || done !== 1'b0 || wr_count !== 5'd0)
            $display("FAIL hold_reload got ld=%b dn=%b cnt=%0d want 1/0/0",
                     loading, done, wr_count);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'h30 + 8'(i);
            tick();
        end
        wr_valid = 1'b0;
        n_chk++;
        if (wr_count !== 5'd7)
            $display("FAIL areset_pre got cnt=%0d want 7", wr_count);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({wr_ready, loading, done, wr_count} !== 8'h00)
            $display("FAIL areset_outputs got rdy=%b ld=%b dn=%b cnt=%0d want 0",
                     wr_ready, loading, done, wr_count);
        else n_pass++;
        for (int a = 0; a < 8; a++) begin
            rd_addr = 4'(a);
            #0.5;
            n_chk++;
            if (rd_data !== 8'h00 || rd_valid !== 1'b0)
                $display("FAIL areset_read[%0d] got %0h/%b want 0/0",
                         a, rd_data, rd_valid);
            else n_pass++;
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_restart();
        test_done_hold();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
